// File: rtl/video_pattern_stage.sv
// video_pattern_stage: per-pixel pattern source / overlay between the video source mux and the HDMI encoder.
// Latency: LATENCY enabled cycles for rgb, blanking and syncs alike; mode_o is not delayed.
// Backpressure: none; cen_i=0 freezes every register (video clock enable, no ready path).
// Ports: clk_i, rst_n_i (async active-low); cen_i clock enable; mode_i requested mode (0 pass,
//   1 solid, 2 bars, 3 box), taken only on a Vblank rising edge; vid_rgb_i/vh_blank_i/dvh_sync_i
//   video in; vid_rgb_o/vh_blank_o/dvh_sync_o delayed video out; mode_o mode currently in effect.
// Build option: define VIDEO_PATTERN_BOX_EN to include the mode-3 moving inverted box overlay;
//   without it mode 3 passes video through unchanged (mode_o still reports 3).
module video_pattern_stage #(
  parameter int          H_ACTIVE  = 1280,
  parameter int          V_ACTIVE  = 720,
  parameter int          LATENCY   = 2,
  parameter logic [23:0] SOLID_RGB = 24'hD0_10_80,
  parameter int          BOX_SIZE  = 64,
  parameter int          BOX_STEP  = 4,
  parameter int          BOX_Y     = 328
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic        cen_i,
  input  logic [1:0]  mode_i,
  input  logic [23:0] vid_rgb_i,
  input  logic [1:0]  vh_blank_i,
  input  logic [2:0]  dvh_sync_i,
  output logic [23:0] vid_rgb_o,
  output logic [1:0]  vh_blank_o,
  output logic [2:0]  dvh_sync_o,
  output logic [1:0]  mode_o
);

  localparam int BAR_W = H_ACTIVE / 8;
  localparam int PXW   = (BAR_W > 1) ? $clog2(BAR_W) : 1;
  localparam int HW    = $clog2(H_ACTIVE);
  localparam int VW    = $clog2(V_ACTIVE + 1) + 1;
  localparam int BXW   = $clog2(H_ACTIVE + 1);

  localparam bit CFG_OK = (H_ACTIVE % 8 == 0) && (H_ACTIVE >= 8) && (LATENCY >= 1) &&
                          (BOX_SIZE <= H_ACTIVE) && (BOX_Y + BOX_SIZE <= V_ACTIVE) &&
                          (BOX_STEP >= 0);

  generate
    if (!CFG_OK) begin : g_cfg_err
      $error("video_pattern_stage: illegal parameter combination");
    end
  endgenerate

  typedef struct packed {
    logic [23:0] rgb;
    logic [1:0]  blank;
    logic [2:0]  sync;
  } pix_t;

  logic hb, vb, active, frame_edge;
  assign hb     = vh_blank_i[0];
  assign vb     = vh_blank_i[1];
  assign active = (vh_blank_i == 2'b00);

  logic [PXW-1:0] bar_px_q, bar_px_d;
  logic [2:0]     bar_idx_q, bar_idx_d;
  logic           vb_prev_q, vb_prev_d;
  logic [1:0]     mode_q, mode_d;
  logic [23:0]    bar_rgb, px_rgb;
  pix_t           pipe_q [LATENCY];
  pix_t           pipe_d [LATENCY];

  assign frame_edge = vb && !vb_prev_q;

  // Stage 0: bar counters, frame edge and mode register.
  always_comb begin
    bar_px_d  = bar_px_q;
    bar_idx_d = bar_idx_q;
    if (hb) begin
      bar_px_d  = '0;
      bar_idx_d = '0;
    end else if (bar_px_q == PXW'(BAR_W - 1)) begin
      bar_px_d  = '0;
      // Overlong lines stay on the last bar instead of wrapping.
      bar_idx_d = (bar_idx_q == 3'd7) ? bar_idx_q : bar_idx_q + 3'd1;
    end else begin
      bar_px_d  = bar_px_q + PXW'(1);
    end
    vb_prev_d = vb;
    mode_d    = frame_edge ? mode_i : mode_q;
  end

`ifdef VIDEO_PATTERN_BOX_EN
  logic [HW-1:0]  h_cnt_q, h_cnt_d;
  logic [VW-1:0]  v_cnt_q, v_cnt_d;
  logic           hb_prev_q, hb_prev_d;
  logic [BXW-1:0] box_x_q, box_x_d;
  logic           in_box;

  always_comb begin
    h_cnt_d = hb ? '0 : ((h_cnt_q == HW'(H_ACTIVE - 1)) ? h_cnt_q : h_cnt_q + HW'(1));
    // Vblank clear wins over the Hblank-edge increment in the same cycle.
    if (vb)
      v_cnt_d = '0;
    else if (hb && !hb_prev_q)
      v_cnt_d = (v_cnt_q == '1) ? v_cnt_q : v_cnt_q + VW'(1);
    else
      v_cnt_d = v_cnt_q;
    hb_prev_d = hb;
    box_x_d   = box_x_q;
    if (frame_edge)
      box_x_d = (int'(box_x_q) + BOX_SIZE + BOX_STEP > H_ACTIVE) ? '0 : box_x_q + BXW'(BOX_STEP);
  end

  assign in_box = (int'(h_cnt_q) >= int'(box_x_q)) && (int'(h_cnt_q) < int'(box_x_q) + BOX_SIZE) &&
                  (int'(v_cnt_q) >= BOX_Y) && (int'(v_cnt_q) < BOX_Y + BOX_SIZE);

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      h_cnt_q   <= '0;
      v_cnt_q   <= '0;
      hb_prev_q <= 1'b0;
      box_x_q   <= '0;
    end else if (cen_i) begin
      h_cnt_q   <= h_cnt_d;
      v_cnt_q   <= v_cnt_d;
      hb_prev_q <= hb_prev_d;
      box_x_q   <= box_x_d;
    end
  end
`endif

  always_comb begin
    bar_rgb = 24'h000000;
    case (bar_idx_q)
      3'd0:    bar_rgb = 24'hFFFFFF;
      3'd1:    bar_rgb = 24'hFFFF00;
      3'd2:    bar_rgb = 24'h00FFFF;
      3'd3:    bar_rgb = 24'h00FF00;
      3'd4:    bar_rgb = 24'hFF00FF;
      3'd5:    bar_rgb = 24'hFF0000;
      3'd6:    bar_rgb = 24'h0000FF;
      default: bar_rgb = 24'h000000;
    endcase
  end

  // Stage 1 pixel function; counters are used before this cycle's update.
  always_comb begin
    px_rgb = vid_rgb_i;
    case (mode_q)
      2'd1:    px_rgb = active ? SOLID_RGB : 24'h000000;
      2'd2:    px_rgb = active ? bar_rgb : 24'h000000;
`ifdef VIDEO_PATTERN_BOX_EN
      2'd3:    px_rgb = (active && in_box) ? ~vid_rgb_i : vid_rgb_i;
`endif
      default: px_rgb = vid_rgb_i;
    endcase
  end

  always_comb begin
    pipe_d[0] = '{rgb: px_rgb, blank: vh_blank_i, sync: dvh_sync_i};
    for (int i = 1; i < LATENCY; i++)
      pipe_d[i] = pipe_q[i-1];
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      bar_px_q  <= '0;
      bar_idx_q <= '0;
      vb_prev_q <= 1'b0;
      mode_q    <= 2'd0;
      for (int i = 0; i < LATENCY; i++)
        pipe_q[i] <= '0;
    end else if (cen_i) begin
      bar_px_q  <= bar_px_d;
      bar_idx_q <= bar_idx_d;
      vb_prev_q <= vb_prev_d;
      mode_q    <= mode_d;
      pipe_q    <= pipe_d;
    end
  end

  assign vid_rgb_o  = pipe_q[LATENCY-1].rgb;
  assign vh_blank_o = pipe_q[LATENCY-1].blank;
  assign dvh_sync_o = pipe_q[LATENCY-1].sync;
  assign mode_o     = mode_q;

endmodule

// File: tb/tb_video_pattern_stage.sv
// tb_video_pattern_stage: self-checking bench for video_pattern_stage on a 16x8 raster.
// Latency: expected outputs are the reference model's pixels delayed by LAT enabled cycles.
// Backpressure: cen_i is driven low in gaps; the model holds its state across them.
`timescale 1ns/1ps
module tb_video_pattern_stage;

  localparam int H_ACT  = 16;
  localparam int V_ACT  = 8;
  localparam int H_TOT  = 20;
  localparam int V_TOT  = 10;
  localparam int FRAME  = H_TOT * V_TOT;
  localparam int LAT    = 2;
  localparam int BOX_SZ = 4;
  localparam int BOX_ST = 4;
  localparam int BOX_Y0 = 2;
  localparam logic [23:0] SOLID = 24'hD01080;
`ifdef VIDEO_PATTERN_BOX_EN
  localparam bit BOX_EN = 1'b1;
`else
  localparam bit BOX_EN = 1'b0;
`endif

  typedef struct packed {
    logic [23:0] rgb;
    logic [1:0]  blank;
    logic [2:0]  sync;
  } rec_t;

  typedef struct {
    logic [1:0]  mode;
    logic [23:0] rgb;
    int          x;
    int          y;
    logic [23:0] exp;
    string       name;
  } vec_t;

  logic        clk_i;
  logic        rst_n_i;
  logic        cen_i;
  logic [1:0]  mode_i;
  logic [23:0] vid_rgb_i;
  logic [1:0]  vh_blank_i;
  logic [2:0]  dvh_sync_i;
  logic [23:0] vid_rgb_o;
  logic [1:0]  vh_blank_o;
  logic [2:0]  dvh_sync_o;
  logic [1:0]  mode_o;

  video_pattern_stage #(
    .H_ACTIVE(H_ACT), .V_ACTIVE(V_ACT), .LATENCY(LAT), .SOLID_RGB(SOLID),
    .BOX_SIZE(BOX_SZ), .BOX_STEP(BOX_ST), .BOX_Y(BOX_Y0)
  ) dut (
    .clk_i(clk_i), .rst_n_i(rst_n_i), .cen_i(cen_i), .mode_i(mode_i),
    .vid_rgb_i(vid_rgb_i), .vh_blank_i(vh_blank_i), .dvh_sync_i(dvh_sync_i),
    .vid_rgb_o(vid_rgb_o), .vh_blank_o(vh_blank_o), .dvh_sync_o(dvh_sync_o),
    .mode_o(mode_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  int          checks = 0;
  int          failures = 0;
  int          pos_x, pos_y, m_box;
  logic [1:0]  m_mode;
  rec_t        exp_out;
  rec_t        mq[$];
  logic [23:0] cur_rgb;
  logic [23:0] bar_tab [8];
  vec_t        tbl[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h, expected %h (next input pos x=%0d y=%0d)", name, act, exp, pos_x, pos_y);
    end
  endtask

  function automatic logic [2:0] rnd3();
    return 3'($urandom);
  endfunction

  function automatic logic [23:0] model_pixel(input int x, input int y, input logic [23:0] rgb);
    bit act;
    act = (x < H_ACT) && (y < V_ACT);
    case (m_mode)
      2'd1: return act ? SOLID : 24'h0;
      2'd2: return act ? bar_tab[x / (H_ACT / 8)] : 24'h0;
      2'd3: begin
        if (BOX_EN && act && x >= m_box && x < m_box + BOX_SZ && y >= BOX_Y0 && y < BOX_Y0 + BOX_SZ)
          return ~rgb;
        return rgb;
      end
      default: return rgb;
    endcase
  endfunction

  task automatic model_reset();
    pos_x = 0; pos_y = 0; m_mode = 2'd0; m_box = 0; exp_out = '0;
    mq.delete();
    for (int i = 0; i < LAT - 1; i++) mq.push_back('0);
  endtask

  // One video clock: apply inputs for the current raster position, clock, update model, compare.
  task automatic drive_cycle(input logic en, input logic [23:0] rgb, input logic [2:0] sync);
    logic hb, vb;
    logic [1:0] mi;
    rec_t rec;
    hb = (pos_x >= H_ACT);
    vb = (pos_y >= V_ACT);
    mi = mode_i;
    cen_i = en; vid_rgb_i = rgb; vh_blank_i = {vb, hb}; dvh_sync_i = sync;
    @(posedge clk_i); #1;
    if (en) begin
      rec.rgb = model_pixel(pos_x, pos_y, rgb);
      rec.blank = {vb, hb};
      rec.sync = sync;
      if (pos_y == V_ACT && pos_x == 0) begin
        m_mode = mi;
        m_box = (m_box + BOX_SZ + BOX_ST > H_ACT) ? 0 : m_box + BOX_ST;
      end
      mq.push_back(rec);
      exp_out = mq.pop_front();
      pos_x++;
      if (pos_x == H_TOT) begin
        pos_x = 0;
        pos_y = (pos_y + 1 == V_TOT) ? 0 : pos_y + 1;
      end
    end
    chk("stream", {1'b0, vid_rgb_o, vh_blank_o, dvh_sync_o, mode_o},
        {1'b0, exp_out.rgb, exp_out.blank, exp_out.sync, m_mode});
  endtask

  task automatic run_until(input int x, input int y);
    int n = 0;
    while (!(pos_x == x && pos_y == y)) begin
      if (n > 2 * FRAME) begin
        failures++; checks++;
        $display("FAIL run_until: position %0d,%0d not reached", x, y);
        return;
      end
      drive_cycle(1'b1, cur_rgb, rnd3());
      n++;
    end
  endtask

  task automatic check_at(input int x, input int y, input logic [23:0] exp, input string name);
    run_until(x, y);
    repeat (LAT) drive_cycle(1'b1, cur_rgb, rnd3());
    chk(name, {8'h0, vid_rgb_o}, {8'h0, exp});
  endtask

  task automatic load_mode(input logic [1:0] m);
    mode_i = m;
    run_until(0, V_ACT);
    drive_cycle(1'b1, cur_rgb, rnd3());
  endtask

  task automatic add_vec(input logic [1:0] m, input logic [23:0] rgb, input int x, input int y,
                         input logic [23:0] exp, input string name);
    vec_t v;
    v.mode = m; v.rgb = rgb; v.x = x; v.y = y; v.exp = exp; v.name = name;
    tbl.push_back(v);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [23:0] inv;
    bar_tab[0] = 24'hFFFFFF; bar_tab[1] = 24'hFFFF00; bar_tab[2] = 24'h00FFFF; bar_tab[3] = 24'h00FF00;
    bar_tab[4] = 24'hFF00FF; bar_tab[5] = 24'hFF0000; bar_tab[6] = 24'h0000FF; bar_tab[7] = 24'h000000;

    add_vec(2'd1, 24'h123456,  3, 1, 24'hD01080, "solid_active");
    add_vec(2'd1, 24'h123456, 17, 1, 24'h000000, "solid_hblank");
    add_vec(2'd1, 24'h654321, 15, 7, 24'hD01080, "solid_last_px");
    add_vec(2'd2, 24'h123456,  0, 0, 24'hFFFFFF, "bar0_a");
    add_vec(2'd2, 24'h123456,  1, 0, 24'hFFFFFF, "bar0_b");
    add_vec(2'd2, 24'h123456,  2, 3, 24'hFFFF00, "bar1");
    add_vec(2'd2, 24'h123456,  5, 4, 24'h00FFFF, "bar2");
    add_vec(2'd2, 24'h123456,  6, 7, 24'h00FF00, "bar3");
    add_vec(2'd2, 24'h123456,  9, 2, 24'hFF00FF, "bar4");
    add_vec(2'd2, 24'h123456, 10, 2, 24'hFF0000, "bar5");
    add_vec(2'd2, 24'h123456, 13, 6, 24'h0000FF, "bar6");
    add_vec(2'd2, 24'h777777, 15, 1, 24'h000000, "bar7");
    add_vec(2'd2, 24'h777777, 18, 3, 24'h000000, "bar_hblank");
    add_vec(2'd0, 24'hABCDEF, 18, 3, 24'hABCDEF, "pass_blank");

    rst_n_i = 1'b0; cen_i = 1'b0; mode_i = 2'd0; vid_rgb_i = '0; vh_blank_i = '0; dvh_sync_i = '0;
    cur_rgb = 24'h0;
    model_reset();
    repeat (3) @(posedge clk_i);
    #1;
    chk("reset_out", {1'b0, vid_rgb_o, vh_blank_o, dvh_sync_o, mode_o}, 32'h0);
    rst_n_i = 1'b1;

    // Mode requested before any Vblank edge: still pass-through.
    mode_i = 2'd1;
    drive_cycle(1'b1, 24'h111111, 3'd1);
    drive_cycle(1'b1, 24'h222222, 3'd2);
    drive_cycle(1'b1, 24'h333333, 3'd3);
    chk("pre_edge_pass", {8'h0, vid_rgb_o}, {8'h0, 24'h222222});
    chk("pre_edge_mode", {30'h0, mode_o}, {30'h0, 2'd0});
    cur_rgb = 24'h5A5A5A;
    check_at(2, 0, SOLID, "first_solid");
    chk("first_solid_mode", {30'h0, mode_o}, {30'h0, 2'd1});

    foreach (tbl[i]) begin
      cur_rgb = tbl[i].rgb;
      load_mode(tbl[i].mode);
      check_at(tbl[i].x, tbl[i].y, tbl[i].exp, tbl[i].name);
    end

    // Mid-frame mode request is ignored until the next frame.
    cur_rgb = 24'h2468AC;
    load_mode(2'd2);
    run_until(0, 3);
    mode_i = 2'd1;
    check_at(9, 5, 24'hFF00FF, "toggle_hold_rgb");
    chk("toggle_hold_mode", {30'h0, mode_o}, {30'h0, 2'd2});
    check_at(9, 1, SOLID, "toggle_apply_rgb");
    chk("toggle_apply_mode", {30'h0, mode_o}, {30'h0, 2'd1});

    // Clock-enable gaps mid-line and across the Hblank edge.
    load_mode(2'd2);
    run_until(4, 2);
    repeat (5) drive_cycle(1'b0, 24'($urandom), rnd3());
    check_at(4, 2, 24'h00FFFF, "cen_resume");
    run_until(15, 3);
    repeat (5) drive_cycle(1'b0, 24'($urandom), rnd3());
    check_at(16, 3, 24'h000000, "cen_hblank_rgb");
    chk("cen_hblank_blank", {30'h0, vh_blank_o}, {30'h0, 2'b01});

    // Asynchronous reset mid-line, sampled before any further clock edge.
    run_until(3, 4);
    #2;
    rst_n_i = 1'b0;
    #1;
    chk("async_reset", {1'b0, vid_rgb_o, vh_blank_o, dvh_sync_o, mode_o}, 32'h0);
    repeat (2) @(posedge clk_i);
    #1;
    model_reset();
    rst_n_i = 1'b1;

    // Moving box: box_x 4, 8, 12, then wraps to 0.
    inv = BOX_EN ? 24'hEDCBA9 : 24'h123456;
    cur_rgb = 24'h123456;
    load_mode(2'd3);
    check_at( 3, 2, 24'h123456, "box1_left_out");
    check_at( 4, 3, inv,        "box1_left_in");
    check_at( 8, 4, 24'h123456, "box1_right_out");
    check_at( 7, 5, inv,        "box1_right_in");
    check_at( 4, 6, 24'h123456, "box1_below");
    check_at( 7, 3, 24'h123456, "box2_left_out");
    check_at(12, 3, 24'h123456, "box2_right_out");
    check_at( 8, 4, inv,        "box2_left_in");
    check_at(11, 5, inv,        "box2_right_in");
    check_at(11, 2, 24'h123456, "box3_left_out");
    check_at(12, 3, inv,        "box3_left_in");
    check_at(15, 5, inv,        "box3_right_in");
    check_at( 0, 1, 24'h123456, "box4_above");
    check_at( 0, 2, inv,        "box4_wrap_in");
    check_at( 4, 4, 24'h123456, "box4_right_out");
    check_at( 3, 5, inv,        "box4_right_in");

    // Randomized traffic against the model.
    for (int n = 0; n < 6000; n++) begin
      if ($urandom_range(0, 149) == 0) mode_i = 2'($urandom);
      drive_cycle(($urandom_range(0, 9) != 0), 24'($urandom), rnd3());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/video_pattern_stage.md
# video_pattern_stage

Parametrised video processing stage for the HDMI output path: each pixel is either the input video, a solid colour, 8-bar colour bars, or input video with a moving inverted box overlay. The mode is sampled only at frame boundaries, and the pipeline depth is configurable. RGB, blanking and syncs are all delayed by the same latency. It sits between the video source mux and the HDMI encoder.

## Interface
- H_ACTIVE, 1280, active pixels per line; must be a multiple of 8.
- V_ACTIVE, 720, active lines per frame.
- LATENCY, 2, total pipeline depth in enabled cycles; must be ≥1.
- SOLID_RGB, 24'hD0_10_80, colour for mode 1.
- BOX_SIZE, 64, box edge length in pixels/lines; must satisfy BOX_SIZE ≤ H_ACTIVE.
- BOX_STEP, 4, horizontal box advance per frame.
- BOX_Y, 328, top line of box; must satisfy BOX_Y+BOX_SIZE ≤ V_ACTIVE.
- clk_i  in  1  single clock.
- rst_n_i  in  1  asynchronous active-low reset.
- cen_i  in  1  video clock enable.
- mode_i  in  2  requested mode: 0 pass, 1 solid, 2 bars, 3 box.
- vid_rgb_i  in  24  R[23:16], G[15:8], B[7:0].
- vh_blank_i  in  2  {Vblank, Hblank}.
- dvh_sync_i  in  3  {D_sync, Vsync, Hsync}.
- vid_rgb_o  out  24  processed RGB, delayed.
- vh_blank_o  out  2  blanking, delayed.
- dvh_sync_o  out  3  syncs, delayed.
- mode_o  out  2  mode currently in effect.

## Operation
- All state advances only when cen_i=1. When cen_i=0, all state holds.
- **Counters (stage 0, combinational use of current values):**
  - h_cnt: cleared while Hblank=1; otherwise +1 per pixel, saturating at H_ACTIVE-1.
  - v_cnt: cleared while Vblank=1; otherwise +1 on each Hblank rising edge (hb_prev=0, Hblank=1).
  - bar_px/bar_idx: both cleared while Hblank=1. Per active pixel, bar_px increments; at BAR_W-1 (BAR_W=H_ACTIVE/8) bar_px wraps to 0 and bar_idx +1, saturating at 7.
- **Frame boundary = Vblank rising edge (vb_prev=0, Vblank=1).** On this edge:
  - The mode register is loaded from mode_i.
  - box_x updates: if box_x+BOX_SIZE+BOX_STEP > H_ACTIVE then box_x←0, else box_x←box_x+BOX_STEP.
  - mode_i changes at any other time have no effect.
- **Pixel function (stage 1 register), using counter values before their update in that cycle:**
  - Mode 0: vid_rgb_i.
  - Mode 1: SOLID_RGB when vh_blank_i=0; 24'h0 otherwise.
  - Mode 2: bar colour when vh_blank_i=0; 24'h0 otherwise. Bar colours by bar_idx 0..7: FFFFFF, FFFF00, 00FFFF, 00FF00, FF00FF, FF0000, 0000FF, 000000.
  - Mode 3: ~vid_rgb_i when vh_blank_i=0 and box_x≤h_cnt<box_x+BOX_SIZE and BOX_Y≤v_cnt<BOX_Y+BOX_SIZE; vid_rgb_i otherwise.
- Stages 2..LATENCY: plain shift registers carrying rgb, blank and sync. With LATENCY=1, stage 1 drives the outputs directly.
- mode_o reflects the mode register and is not delayed.

## Timing
- Latency is exactly LATENCY enabled cycles from input to output for rgb, vh_blank and dvh_sync.
- Mode takes effect on the pixel sampled in the cycle after the Vblank rising edge, which is inside blanking. Active video therefore never switches mode mid-frame.
- **Reset (asynchronous assert, no synchronous release logic required):**
  - All outputs go to 0 and mode_o=0.
  - All counters, hb_prev, vb_prev, box_x and pipeline stages are cleared.
  - After reset the block passes video through until the first Vblank rising edge.
  - Reset mid-frame: counters restart from 0, so the first partial frame may show patterns offset. The next full line and frame are correct.
- Lines longer than H_ACTIVE: h_cnt saturates and bar_idx saturates at 7. No wrap.
- A Vblank rising edge and a Hblank edge in the same cycle: both are honoured. Vblank clears v_cnt, which takes priority over its increment.

## Configuration
- Macro VIDEO_PATTERN_BOX_EN.
  - Defined: mode 3 box overlay and box_x logic are compiled in.
  - Undefined: box logic is removed, and mode 3 behaves exactly as mode 0 (pass-through). mode_o still reports 3.

## Test plan
All scenarios use H_ACTIVE=16, V_ACTIVE=8, LATENCY=2, BOX_SIZE=4, BOX_STEP=4, BOX_Y=2, with 4 blank pixels/line and 2 blank lines.
- Reset, then mode_i=1 with no Vblank edge yet: output equals input delayed by 2 cycles and mode_o=0. After the first Vblank rising edge, active pixels output D01080 and blanked pixels output 000000.
- Mode 2: each active line outputs 2 pixels each of FFFFFF, FFFF00, 00FFFF, 00FF00, FF00FF, FF0000, 0000FF, 000000.
- Mode 3 with input 123456 and macro defined: frame 1 has EDCBA9 at h 4..7 on lines 2..5. The box advances 4 pixels per frame, and box_x wraps 12→0 after the frame with box_x=12. With the macro undefined, the output is 123456 everywhere.
- Toggle mode_i mid-frame: mode_o and output are unchanged until the next Vblank rising edge.
- Hold cen_i=0 for 5 cycles mid-line: outputs and counters freeze. On resumption the pattern continues from the same pixel, and dvh_sync_o and vh_blank_o stay aligned with rgb at 2-cycle latency.
- Assert rst_n_i low mid-line: outputs go to 0 immediately, without waiting for a clock edge.
